btb_assoc: RTL
==============

# btb_assoc

Set-associative branch target buffer with per-entry 2-bit saturating direction counters and tree pseudo-LRU replacement. Sits in the fetch stage: IF looks up the current PC combinationally to produce a predicted next PC, and EX writes back resolved branch outcome and target. It generalises the direct-mapped single-bit BTB to configurable sets, ways and counter width, and adds tag/valid checking, hysteresis and flush.

## Interface
- S_INDEX, 4: log2 of set count; index = pc[S_INDEX+1:2].
- WAYS, 2: associativity, power of two, 1..8.
- CNT_W, 2: direction counter width, ≥1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  invalidate all entries.
- if_pc_in  in  32  fetch PC to look up.
- predicted_pc  out  32  predicted target; valid only when btb_flag == 2'b11.
- btb_flag  out  2  00 miss, 10 hit/predict not-taken, 11 hit/predict taken.
- update_btb  in  1  EX has a resolved conditional branch this cycle.
- ex_pc_in  in  32  PC of the resolved branch.
- br_out  in  32  resolved target address.
- br_taken  in  1  actual direction.

## Operation
- Entry: valid, tag = pc[31:S_INDEX+2], target[31:0], cnt[CNT_W-1:0]. Predict taken iff cnt MSB = 1.
- Lookup (combinational): hit when some way in set if_idx has valid && tag match. On hit, btb_flag = {1, cnt MSB}; predicted_pc = target if taken, else 0. On miss, flag 00, predicted_pc 0.
- Update on update_btb, set ex_idx:
  - Hit: cnt saturating +1 if br_taken (stop at all-ones), −1 if not (stop at 0). target <= br_out only when br_taken. Touch way in PLRU.
  - Miss, br_taken=1: allocate victim = lowest-index invalid way, else PLRU victim. Write valid=1, tag, target=br_out, cnt = 10…0 (weakly taken). Touch way.
  - Miss, br_taken=0: no allocation, no state change.
- At most one way per set matches a given tag; allocation only on miss guarantees this.
- Lookups never modify PLRU or counters.
- flush: clears all valid bits next edge; tags/targets/counters/PLRU untouched. flush and update_btb in same cycle: flush wins, update dropped.
- CNT_W = 1: counter is the direction bit; allocate value 1.
- WAYS = 1: PLRU absent, victim always way 0.

## Timing
- Lookup: zero latency; outputs depend only on if_pc_in and registered state.
- Update: visible to lookups from the cycle after the update edge. Same-cycle lookup of an entry being updated sees pre-update state (no bypass).
- Reset: all valid bits, counters, tags, targets and PLRU bits cleared in one cycle; while rst high and in the cycle after, btb_flag = 00, predicted_pc = 0. rst has priority over flush and update_btb.
- All state changes on posedge clk only.

## Structure
- Package btb_pkg: btb_entry_t struct (valid, tag, target, cnt, widths from parameters via parameterised localparams), btb_flag_e enum (BTB_MISS=2'b00, BTB_HIT_NT=2'b10, BTB_HIT_T=2'b11), counter init constant.
- Sub-module btb_plru: one instance per set; WAYS-1 tree bits; inputs touch_en, touch_way; output victim_way; synchronous reset to 0 (victim way 0).
- Top holds entry arrays, hit/way-select logic, counter saturation, allocation.

## Test plan
- Reset then lookup 0x0000_0040 -> flag 00, predicted_pc 0; update not-taken at 0x40 -> still 00 (no allocation).
- Update taken pc 0x40 target 0x100 -> next cycle lookup 0x40 gives flag 11, predicted_pc 0x100; lookup 0x440 (same index, different tag) gives 00.
- Counter hysteresis (CNT_W=2): allocate taken (10), one not-taken -> 01, flag 10; one taken -> 10, flag 11; three taken then check saturation at 11; four not-taken saturates 00, entry stays valid, flag 10.
- Replacement (WAYS=2): allocate taken at 0x40, 0x440, touch 0x40 via update, allocate 0x840 -> 0x440 evicted (lookup 00), 0x40 and 0x840 hit.
- Same-cycle: update taken 0x80->0x200 while lookup 0x80 -> that cycle flag 00, next cycle 11/0x200; flush with simultaneous update -> next cycle all lookups 00.
- rst asserted mid-operation with valid entries -> all lookups 00 afterwards, PLRU victim way 0.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and constants for the set-associative branch target buffer.
// Default geometry: 16 sets, 2 ways, 2-bit direction counters.
package btb_pkg;

  localparam int BTB_S_INDEX = 4;
  localparam int BTB_WAYS    = 2;
  localparam int BTB_CNT_W   = 2;
  localparam int BTB_TAG_W   = 30 - BTB_S_INDEX;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic [BTB_CNT_W-1:0] cnt;
  } btb_entry_t;

  typedef enum logic [1:0] {
    BTB_MISS   = 2'b00,
    BTB_HIT_NT = 2'b10,
    BTB_HIT_T  = 2'b11
  } btb_flag_e;

  // Weakly taken: only the MSB set.
  function automatic logic [31:0] cnt_init(input int w);
    return 32'(1) << (w - 1);
  endfunction

  localparam logic [BTB_CNT_W-1:0] BTB_CNT_INIT =
    BTB_CNT_W'(cnt_init(BTB_CNT_W));

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU state for one BTB set.
// Node n (heap order, root 1) lives in tree_q[n-1]; 0 steers left.
module btb_plru #(
  parameter int WAYS = 2,
  parameter int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          touch_en,
  input  logic [WW-1:0] touch_way,
  output logic [WW-1:0] victim_way
);

  if (WAYS > 1) begin : g_tree
    localparam int LV = $clog2(WAYS);

    logic [WAYS-2:0] tree_q;
    logic [WAYS-2:0] tree_nxt;

    always_comb begin
      int node;
      node = 1;
      for (int l = 0; l < LV; l++) begin
        node = 2 * node + int'(tree_q[node-1]);
      end
      victim_way = WW'(node - WAYS);
    end

    // Point every node on the touched path away from it.
    always_comb begin
      int node;
      logic dir;
      tree_nxt = tree_q;
      node = 1;
      for (int l = 0; l < LV; l++) begin
        dir = touch_way[LV-1-l];
        tree_nxt[node-1] = ~dir;
        node = 2 * node + int'(dir);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        tree_q <= '0;
      end else if (touch_en) begin
        tree_q <= tree_nxt;
      end
    end
  end else begin : g_none
    logic unused;
    assign unused = ^{clk, rst, touch_en, touch_way};
    assign victim_way = '0;
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational IF lookup, EX-side update with
// saturating direction counters and tree-PLRU allocation.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int S_INDEX = 4,
  parameter int WAYS    = 2,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] if_pc_in,
  output logic [31:0] predicted_pc,
  output logic [1:0]  btb_flag,
  input  logic        update_btb,
  input  logic [31:0] ex_pc_in,
  input  logic [31:0] br_out,
  input  logic        br_taken
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 30 - S_INDEX;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t ent_q [SETS][WAYS];

  logic [S_INDEX-1:0] if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic [S_INDEX-1:0] ex_idx;
  logic [TAG_W-1:0]   ex_tag;

  assign if_idx = if_pc_in[S_INDEX+1:2];
  assign if_tag = if_pc_in[31:S_INDEX+2];
  assign ex_idx = ex_pc_in[S_INDEX+1:2];
  assign ex_tag = ex_pc_in[31:S_INDEX+2];

  logic unused;
  assign unused = ^{if_pc_in[1:0], ex_pc_in[1:0]};

  logic          if_hit;
  logic [WW-1:0] if_way;
  entry_t        if_ent;

  always_comb begin
    if_hit = 1'b0;
    if_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ent_q[if_idx][w].valid && ent_q[if_idx][w].tag == if_tag) begin
        if_hit = 1'b1;
        if_way = WW'(w);
      end
    end
    if_ent = ent_q[if_idx][if_way];
  end

  btb_flag_e flag;

  always_comb begin
    flag         = BTB_MISS;
    predicted_pc = '0;
    if (!rst && if_hit) begin
      if (if_ent.cnt[CNT_W-1]) begin
        flag         = BTB_HIT_T;
        predicted_pc = if_ent.target;
      end else begin
        flag = BTB_HIT_NT;
      end
    end
  end

  assign btb_flag = flag;

  logic          ex_hit;
  logic [WW-1:0] ex_way;
  entry_t        ex_ent;

  always_comb begin
    ex_hit = 1'b0;
    ex_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ent_q[ex_idx][w].valid && ent_q[ex_idx][w].tag == ex_tag) begin
        ex_hit = 1'b1;
        ex_way = WW'(w);
      end
    end
    ex_ent = ent_q[ex_idx][ex_way];
  end

  logic [WW-1:0] plru_victim [SETS];
  logic [WW-1:0] alloc_way;
  logic [WW-1:0] upd_way;
  logic          touch_en;

  // Fill holes before evicting anything live.
  always_comb begin
    logic found;
    found     = 1'b0;
    alloc_way = plru_victim[ex_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !ent_q[ex_idx][w].valid) begin
        alloc_way = WW'(w);
        found     = 1'b1;
      end
    end
  end

  assign upd_way  = ex_hit ? ex_way : alloc_way;
  assign touch_en = update_btb && !flush && (ex_hit || br_taken);

  for (genvar s = 0; s < SETS; s++) begin : g_set
    btb_plru #(
      .WAYS (WAYS),
      .WW   (WW)
    ) u_plru (
      .clk        (clk),
      .rst        (rst),
      .touch_en   (touch_en && (ex_idx == S_INDEX'(s))),
      .touch_way  (upd_way),
      .victim_way (plru_victim[s])
    );
  end

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = ex_ent.cnt;
    if (br_taken) begin
      if (ex_ent.cnt != CNT_MAX) cnt_nxt = ex_ent.cnt + 1'b1;
    end else begin
      if (ex_ent.cnt != '0) cnt_nxt = ex_ent.cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          ent_q[s][w] <= '0;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          ent_q[s][w].valid <= 1'b0;
        end
      end
    end else if (update_btb) begin
      if (ex_hit) begin
        ent_q[ex_idx][ex_way].cnt <= cnt_nxt;
        if (br_taken) ent_q[ex_idx][ex_way].target <= br_out;
      end else if (br_taken) begin
        ent_q[ex_idx][alloc_way] <= '{1'b1, ex_tag, br_out, CNT_INIT};
      end
    end
  end

endmodule
